// File: rtl/trace_pkg.sv
// Shared definitions for the processor trace buffer: capture-session states and pointer width helper.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } trace_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/proc_trace_buffer_if.sv
// Capture/readout bus of the trace buffer; Rd_Ts and TS_W exist only with TRACE_TIMESTAMP_EN defined.
interface proc_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 16
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
);

    logic                       Arm;
    logic                       Sample_Valid;
    logic [NUM_CH*DATA_W-1:0]   Sample_In;
    logic [DATA_W-1:0]          Trig_Match;
    logic [DATA_W-1:0]          Trig_Mask;
    logic [ptr_w(DEPTH)-1:0]    Post_Trig;
    logic                       Rd_Ready;
    logic                       Rd_Valid;
    logic [NUM_CH*DATA_W-1:0]   Rd_Data;
    logic                       Rd_Last;
    logic                       Busy;
    logic                       Wrapped;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]            Rd_Ts;
`endif

    modport master (
        output Arm, Sample_Valid, Sample_In, Trig_Match, Trig_Mask, Post_Trig, Rd_Ready,
`ifdef TRACE_TIMESTAMP_EN
        input  Rd_Ts,
`endif
        input  Rd_Valid, Rd_Data, Rd_Last, Busy, Wrapped
    );

    modport slave (
        input  Arm, Sample_Valid, Sample_In, Trig_Match, Trig_Mask, Post_Trig, Rd_Ready,
`ifdef TRACE_TIMESTAMP_EN
        output Rd_Ts,
`endif
        output Rd_Valid, Rd_Data, Rd_Last, Busy, Wrapped
    );

endinterface

// File: rtl/trace_ram.sv
// Trace storage: one write port and one synchronous read port with read enable; contents never reset.
module trace_ram #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The read register only moves on re_i, which is what holds Rd_Data during a stall.
    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_trace_buffer.sv
// Trigger-qualified circular capture of NUM_CH observation channels with oldest-first readout.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle count with each entry and expose Rd_Ts.
module proc_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 16
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic               Clk,
    input  logic               Rst_n,
    proc_trace_buffer_if.slave bus
);

    localparam int PTR_W    = ptr_w(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int SAMPLE_W = NUM_CH * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W  = SAMPLE_W + TS_W;
`else
    localparam int ENTRY_W  = SAMPLE_W;
`endif
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    trace_state_e     state_q,   state_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] post_q,    post_d;
    logic [PTR_W-1:0] remain_q,  remain_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] fetch_q,   fetch_d;
    logic [CNT_W-1:0] deliver_q, deliver_d;
    logic             wrapped_q, wrapped_d;
    logic             valid_q,   valid_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q,      ts_d;
`endif

    logic               we;
    logic               re;
    logic               hit;
    logic               xfer;
    logic               last;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    assign hit  = (((bus.Sample_In[DATA_W-1:0] ^ bus.Trig_Match) & bus.Trig_Mask) == '0);
    assign xfer = valid_q & bus.Rd_Ready;
    assign last = valid_q && (deliver_q == CNT_W'(1));

`ifdef TRACE_TIMESTAMP_EN
    assign wdata = {ts_q, bus.Sample_In};
`else
    assign wdata = bus.Sample_In;
`endif

    trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .Clk     (Clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            post_q    <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            fetch_q   <= '0;
            deliver_q <= '0;
            wrapped_q <= 1'b0;
            valid_q   <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            post_q    <= post_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            fetch_q   <= fetch_d;
            deliver_q <= deliver_d;
            wrapped_q <= wrapped_d;
            valid_q   <= valid_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    // Post_Trig is PTR_W bits wide, so it can never exceed DEPTH-1 and the trigger entry survives.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        post_d    = post_q;
        remain_d  = remain_q;
        count_d   = count_q;
        fetch_d   = fetch_q;
        deliver_d = deliver_q;
        wrapped_d = wrapped_q;
        valid_d   = valid_q;
        we        = 1'b0;
        re        = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
        ts_d      = ts_q + 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.Arm) begin
                    post_d    = bus.Post_Trig;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    state_d   = ST_ARMED;
`ifdef TRACE_TIMESTAMP_EN
                    ts_d      = '0;
`endif
                end
            end

            ST_ARMED, ST_POST: begin
                if (bus.Sample_Valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q == FULL) begin
                        wrapped_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end

                    if (state_q == ST_ARMED) begin
                        if (hit) begin
                            remain_d = post_q;
                            state_d  = (post_q == '0) ? ST_READ : ST_POST;
                        end
                    end else begin
                        remain_d = remain_q - 1'b1;
                        if (remain_q == PTR_W'(1)) begin
                            state_d = ST_READ;
                        end
                    end

                    // Oldest surviving entry sits count entries behind the post-write pointer.
                    if (state_d == ST_READ) begin
                        rd_ptr_d  = wr_ptr_d - PTR_W'(count_d);
                        fetch_d   = count_d;
                        deliver_d = count_d;
                    end
                end
            end

            ST_READ: begin
                // Prefetch whenever the output slot is empty or being emptied this cycle.
                re = (fetch_q != '0) && (!valid_q || xfer);
                if (re) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    fetch_d  = fetch_q - 1'b1;
                    valid_d  = 1'b1;
                end else if (xfer) begin
                    valid_d = 1'b0;
                end
                if (xfer) begin
                    deliver_d = deliver_q - 1'b1;
                    if (last) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Rd_Valid = valid_q;
    assign bus.Rd_Data  = valid_q ? rdata[SAMPLE_W-1:0] : '0;
    assign bus.Rd_Last  = last;
    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.Wrapped  = wrapped_q;
`ifdef TRACE_TIMESTAMP_EN
    assign bus.Rd_Ts    = valid_q ? rdata[ENTRY_W-1:SAMPLE_W] : '0;
`endif

endmodule
